store_buffer: RTL and testbench

Write buffer between the datapath's memory-access stage and `data_memory`. It takes word stores from the CPU side, queues them in a small FIFO, and retires them into `data_memory` on cycles when the memory port is not needed by a load. Loads always get the memory port that same cycle. If a load address matches a buffered store, the load returns the youngest matching buffered data instead of the memory's value.

---
 rtl/store_buffer.sv | 121 ++++++++++++
 tb/tb_store_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: FIFO write buffer between the memory-access stage and data_memory.
// Loads own the port and forward from the youngest matching entry.
module store_buffer #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int depth         = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [address_width-1:0] cpu_address,
  input  logic [data_width-1:0]    cpu_writeData,
  input  logic                     cpu_memWrite,
  input  logic                     cpu_memRead,
  output logic [data_width-1:0]    cpu_readData,
  output logic                     stall,
  output logic                     empty,
  output logic [$clog2(depth):0]   count,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_writeData,
  output logic                     mem_memWrite,
  output logic                     mem_memRead,
  input  logic [data_width-1:0]    mem_readData
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(depth);

  typedef logic [PW-1:0] ptr_t;

  logic [address_width-1:0] addr_q [depth];
  logic [data_width-1:0]    data_q [depth];
  logic [depth-1:0]         valid_q, valid_d;
  ptr_t                     head_q, head_d;
  ptr_t                     tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;

  logic full, store_req, push, pop;
  logic hit;
  logic [data_width-1:0] fwd;
  ptr_t idx;

  assign full      = (count_q == FULL);
  assign store_req = cpu_memWrite & ~cpu_memRead;
  assign push      = store_req & ~full;
  // Draining on the full-stall cycle frees a slot for the held store.
  assign pop       = ~cpu_memRead & (~cpu_memWrite | full)
                   & (count_q != '0);

  assign stall = store_req & full;
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (push) begin
      tail_d          = tail_q + ptr_t'(1);
      count_d         = count_q + CW'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (pop) begin
      head_d          = head_q + ptr_t'(1);
      count_d         = count_q - CW'(1);
      valid_d[head_q] = 1'b0;
    end
  end

  // Valid entries run head..tail, so the last hit scanned is the youngest.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = head_q;
    for (int i = 0; i < depth; i++) begin
      idx = head_q + ptr_t'(i);
      if (valid_q[idx] && addr_q[idx] == cpu_address) begin
        hit = 1'b1;
        fwd = data_q[idx];
      end
    end
  end

  always_comb begin
    cpu_readData  = '0;
    mem_address   = addr_q[head_q];
    mem_writeData = data_q[head_q];
    mem_memWrite  = pop;
    mem_memRead   = 1'b0;
    if (cpu_memRead) begin
      mem_address  = cpu_address;
      mem_memWrite = 1'b0;
      mem_memRead  = 1'b1;
      cpu_readData = hit ? fwd : mem_readData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload needs no reset; valid bits gate its use.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= cpu_address;
      data_q[tail_q] <= cpu_writeData;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of store_buffer against a word memory model.
// Inputs change at posedge+1; outputs are checked at posedge+2.
module tb_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpu_address, cpu_writeData, cpu_readData;
  logic        cpu_memWrite, cpu_memRead;
  logic        stall, empty;
  logic [2:0]  count;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [64] = '{default: 32'h0};
  int          wr_cnt = 0;
  logic        pre_we = 1'b0;
  logic [5:0]  pre_a  = '0;
  logic [31:0] pre_d  = '0;

  always #5 clock = ~clock;

  store_buffer dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_address   (cpu_address),
    .cpu_writeData (cpu_writeData),
    .cpu_memWrite  (cpu_memWrite),
    .cpu_memRead   (cpu_memRead),
    .cpu_readData  (cpu_readData),
    .stall         (stall),
    .empty         (empty),
    .count         (count),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_memWrite  (mem_memWrite),
    .mem_memRead   (mem_memRead),
    .mem_readData  (mem_readData)
  );

  assign mem_readData = mem[mem_address[7:2]];

  always @(posedge clock) begin
    if (pre_we) mem[pre_a] <= pre_d;
    if (mem_memWrite === 1'b1) begin
      mem[mem_address[7:2]] <= mem_writeData;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
    cpu_memWrite  = w;
    cpu_memRead   = r;
    cpu_address   = a;
    cpu_writeData = d;
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    chk("store_no_stall", {31'b0, stall}, 32'd0);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  int w0;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_memwr", {31'b0, mem_memWrite}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // reset mid-operation
    st(32'h80, 32'h1);
    st(32'h84, 32'h2);
    st(32'h88, 32'h3);
    chk("mid_count3", {29'b0, count}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", {29'b0, count}, 32'd0);
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_memwr", {31'b0, mem_memWrite}, 32'd0);
    reset = 1'b0;
    idle();
    repeat (5) tick();
    chk("mid_no_writes", wr_cnt, 32'd0);
    chk("mid_mem80", mem[6'h20], 32'h0);

    // forwarding
    st(32'h10, 32'hAAAA_AAAA);
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    chk("fwd_data", cpu_readData, 32'hAAAA_AAAA);
    chk("fwd_memwr", {31'b0, mem_memWrite}, 32'd0);
    chk("fwd_memrd", {31'b0, mem_memRead}, 32'd1);
    chk("fwd_addr", mem_address, 32'h10);
    tick();
    chk("fwd_count", {29'b0, count}, 32'd1);
    idle();
    chk("fwd_idle_rd", cpu_readData, 32'h0);
    chk("fwd_drain_wr", {31'b0, mem_memWrite}, 32'd1);
    chk("fwd_drain_a", mem_address, 32'h10);
    tick();
    chk("fwd_empty", {31'b0, empty}, 32'd1);
    chk("fwd_mem10", mem[6'h04], 32'hAAAA_AAAA);

    // youngest match
    pre_we = 1'b1; pre_a = 6'h09; pre_d = 32'h55;
    st(32'h20, 32'h1);
    pre_we = 1'b0;
    st(32'h20, 32'h2);
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    chk("young_data", cpu_readData, 32'h2);
    tick();
    drive(1'b0, 1'b1, 32'h24, 32'h0);
    chk("unbuf_data", cpu_readData, 32'h55);
    tick();
    chk("young_count", {29'b0, count}, 32'd2);
    idle();
    tick();
    chk("young_mid", mem[6'h08], 32'h1);
    tick();
    chk("young_mem20", mem[6'h08], 32'h2);
    chk("young_empty", {31'b0, empty}, 32'd1);

    // full stall
    st(32'h0, 32'hA0);
    st(32'h4, 32'hA1);
    st(32'h8, 32'hA2);
    st(32'hC, 32'hA3);
    chk("full_count4", {29'b0, count}, 32'd4);
    drive(1'b1, 1'b0, 32'h30, 32'h9);
    chk("full_stall", {31'b0, stall}, 32'd1);
    chk("full_memwr", {31'b0, mem_memWrite}, 32'd1);
    chk("full_addr", mem_address, 32'h0);
    chk("full_wdata", mem_writeData, 32'hA0);
    tick();
    chk("full_count3", {29'b0, count}, 32'd3);
    chk("full_nostall", {31'b0, stall}, 32'd0);
    chk("full_accept_memwr", {31'b0, mem_memWrite}, 32'd0);
    tick();
    chk("full_count4b", {29'b0, count}, 32'd4);
    idle();
    repeat (4) tick();
    chk("full_empty", {31'b0, empty}, 32'd1);
    chk("full_mem0", mem[6'h00], 32'hA0);
    chk("full_memC", mem[6'h03], 32'hA3);
    chk("full_mem30", mem[6'h0C], 32'h9);

    // drain order
    st(32'h40, 32'h11);
    st(32'h44, 32'h22);
    st(32'h48, 32'h33);
    w0 = wr_cnt;
    idle();
    chk("ord_a0", mem_address, 32'h40);
    chk("ord_w0", {31'b0, mem_memWrite}, 32'd1);
    tick();
    chk("ord_a1", mem_address, 32'h44);
    tick();
    chk("ord_a2", mem_address, 32'h48);
    chk("ord_d2", mem_writeData, 32'h33);
    tick();
    chk("ord_empty", {31'b0, empty}, 32'd1);
    chk("ord_nwr", wr_cnt - w0, 32'd3);
    chk("ord_m40", mem[6'h10], 32'h11);
    chk("ord_m44", mem[6'h11], 32'h22);
    chk("ord_m48", mem[6'h12], 32'h33);
    chk("ord_idle_wr", {31'b0, mem_memWrite}, 32'd0);

    // load blocks drain
    st(32'h50, 32'h77);
    st(32'h54, 32'h88);
    drive(1'b0, 1'b1, 32'h60, 32'h0);
    chk("lb_wr0", {31'b0, mem_memWrite}, 32'd0);
    tick();
    chk("lb_wr1", {31'b0, mem_memWrite}, 32'd0);
    tick();
    chk("lb_count", {29'b0, count}, 32'd2);
    idle();
    chk("lb_drain_wr", {31'b0, mem_memWrite}, 32'd1);
    chk("lb_drain_a", mem_address, 32'h50);
    tick();
    chk("lb_count1", {29'b0, count}, 32'd1);

    // load and store together: load only
    drive(1'b1, 1'b1, 32'h54, 32'hDEAD);
    chk("ls_stall", {31'b0, stall}, 32'd0);
    chk("ls_memwr", {31'b0, mem_memWrite}, 32'd0);
    chk("ls_fwd", cpu_readData, 32'h88);
    tick();
    chk("ls_count", {29'b0, count}, 32'd1);
    idle();
    tick();
    chk("ls_m54", mem[6'h15], 32'h88);
    chk("ls_empty", {31'b0, empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
